// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - rounding constant and saturation bound helpers for the fixed-point multiplier
package mult_pkg;

    // Helpers return a generously wide vector; callers size-cast to their own width.
    localparam int unsigned MAX_W = 256;

    typedef logic [MAX_W-1:0] wide_t;

    // Round-half-up constant: 2^(frac-1), or zero when there are no fractional bits.
    function automatic wide_t rnd_const(input int unsigned frac);
        if (frac == 0) begin
            return '0;
        end
        return wide_t'(1) << (frac - 1);
    endfunction

    // Most positive two's-complement value of a w-bit word.
    function automatic wide_t sat_max_s(input int unsigned w);
        return (wide_t'(1) << (w - 1)) - wide_t'(1);
    endfunction

    // Bit pattern of the most negative two's-complement value of a w-bit word.
    function automatic wide_t sat_min_s(input int unsigned w);
        return wide_t'(1) << (w - 1);
    endfunction

    // Largest unsigned value of a w-bit word (all ones).
    function automatic wide_t sat_max_u(input int unsigned w);
        return (wide_t'(1) << w) - wide_t'(1);
    endfunction

endpackage

// File: rtl/mult_rnd_sat.sv
// rtl/mult_rnd_sat.sv - combinational round-half-up, shift and saturate of a full-width product
module mult_rnd_sat
    import mult_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FRAC  = 16
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic               mult_signed,
    output logic [WIDTH-1:0]   res,
    output logic               ovf
);

    localparam int EW = 2 * WIDTH + 1;

    localparam logic [EW-1:0]    RND   = EW'(rnd_const(FRAC));
    localparam logic [WIDTH-1:0] S_MAX = WIDTH'(sat_max_s(WIDTH));
    localparam logic [WIDTH-1:0] S_MIN = WIDTH'(sat_min_s(WIDTH));
    localparam logic [WIDTH-1:0] U_MAX = WIDTH'(sat_max_u(WIDTH));

    logic [EW-1:0]        ext;
    logic [EW-1:0]        sum;
    logic signed [EW-1:0] shr_s;
    logic [EW-1:0]        shr_u;
    logic [EW-1:0]        shr;

    always_comb begin
        // One guard bit keeps the rounding add from wrapping in either mode.
        ext   = mult_signed ? {prod[2*WIDTH-1], prod} : {1'b0, prod};
        sum   = ext + RND;
        // Kept in separate assignments so the arithmetic shift is not
        // silently turned logical by mixing signedness in one expression.
        shr_s = $signed(sum) >>> FRAC;
        shr_u = sum >> FRAC;
        shr   = mult_signed ? shr_s : shr_u;

        res = shr[WIDTH-1:0];
        ovf = 1'b0;
        if (mult_signed) begin
            // Fits in WIDTH bits only if every bit from the sign bit up is a copy of it.
            if (!((&shr[EW-1:WIDTH-1]) || !(|shr[EW-1:WIDTH-1]))) begin
                ovf = 1'b1;
                res = shr[EW-1] ? S_MIN : S_MAX;
            end
        end else if (|shr[EW-1:WIDTH]) begin
            ovf = 1'b1;
            res = U_MAX;
        end
    end

endmodule

// File: rtl/mult_fx_pipe.sv
// rtl/mult_fx_pipe.sv - pipelined fixed-point multiplier with rounding, saturation and backpressure
module mult_fx_pipe #(
    parameter int WIDTH  = 64,
    parameter int FRAC   = 16,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             mult_signed_i,
    input  logic [WIDTH-1:0] mult_i1,
    input  logic [WIDTH-1:0] mult_i2,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] mult_o,
    output logic             mult_ovf_o
);

    localparam int PW = 2 * WIDTH;

    logic             en;
    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod_in;
    logic [PW-1:0]    p_final;
    logic             mode_final;
    logic [WIDTH-1:0] res;
    logic             ovf;

    // Whole pipeline advances together; a full, unaccepted output stalls everything.
    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = en;

    // Extending both operands to the product width makes one truncated
    // multiply correct for both signed and unsigned operands.
    always_comb begin
        a_ext   = mult_signed_i ? {{WIDTH{mult_i1[WIDTH-1]}}, mult_i1} : {{WIDTH{1'b0}}, mult_i1};
        b_ext   = mult_signed_i ? {{WIDTH{mult_i2[WIDTH-1]}}, mult_i2} : {{WIDTH{1'b0}}, mult_i2};
        prod_in = a_ext * b_ext;
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stg
        logic vld;
        logic vld_in;

        if (i == 0) begin : g_vsrc
            assign vld_in = in_valid_i;
        end else begin : g_vsrc
            assign vld_in = g_stg[i-1].vld;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= 1'b0;
            end else if (en) begin
                vld <= vld_in;
            end
        end

        // Every stage but the last carries the raw product and its mode bit.
        if (i < STAGES - 1) begin : g_mul
            logic [PW-1:0] prod;
            logic          mode;
            logic [PW-1:0] prod_src;
            logic          mode_src;

            if (i == 0) begin : g_dsrc
                assign prod_src = prod_in;
                assign mode_src = mult_signed_i;
            end else begin : g_dsrc
                assign prod_src = g_stg[i-1].g_mul.prod;
                assign mode_src = g_stg[i-1].g_mul.mode;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod <= '0;
                    mode <= 1'b0;
                end else if (en) begin
                    prod <= prod_src;
                    mode <= mode_src;
                end
            end
        end
    end

    // With a single stage the multiply feeds rounding directly.
    if (STAGES == 1) begin : g_fin
        assign p_final    = prod_in;
        assign mode_final = mult_signed_i;
    end else begin : g_fin
        assign p_final    = g_stg[STAGES-2].g_mul.prod;
        assign mode_final = g_stg[STAGES-2].g_mul.mode;
    end

    mult_rnd_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_rnd_sat (
        .prod        (p_final),
        .mult_signed (mode_final),
        .res         (res),
        .ovf         (ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_o     <= '0;
            mult_ovf_o <= 1'b0;
        end else if (en) begin
            mult_o     <= res;
            mult_ovf_o <= ovf;
        end
    end

    assign out_valid_o = g_stg[STAGES-1].vld;

endmodule

// File: tb/tb_mult_fx_pipe.sv
// tb/tb_mult_fx_pipe.sv - scoreboard bench for mult_fx_pipe at WIDTH=16 FRAC=8 STAGES=3
module tb_mult_fx_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        mult_signed_i = 1'b0;
    logic [15:0] mult_i1 = '0;
    logic [15:0] mult_i2 = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [15:0] mult_o;
    logic        mult_ovf_o;

    always #5 clk = ~clk;

    mult_fx_pipe #(
        .WIDTH  (16),
        .FRAC   (8),
        .STAGES (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .mult_signed_i (mult_signed_i),
        .mult_i1       (mult_i1),
        .mult_i2       (mult_i2),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .mult_o        (mult_o),
        .mult_ovf_o    (mult_ovf_o)
    );

    typedef struct packed {
        logic [15:0] r;
        logic        o;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        lit;
        exp_t        e;
    } stim_t;

    exp_t        exp_q[$];
    stim_t       stim_q[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_out = 0;
    int          n0;
    logic        held_v = 1'b0;
    logic [15:0] held_r = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint p;
        longint r;
        exp_t   e;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'(a) * longint'(b);
        r = (p + 128) >>> 8;
        if (s && r > 32767)        e = '{16'h7FFF, 1'b1};
        else if (s && r < -32768)  e = '{16'h8000, 1'b1};
        else if (!s && r > 65535)  e = '{16'hFFFF, 1'b1};
        else                       e = '{r[15:0], 1'b0};
        return e;
    endfunction

    task automatic add(input logic [15:0] a, input logic [15:0] b, input logic s);
        stim_t t;
        t.a = a; t.b = b; t.s = s; t.lit = 1'b0; t.e = '0;
        stim_q.push_back(t);
    endtask

    task automatic add_lit(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [15:0] r, input logic o);
        stim_t t;
        t.a = a; t.b = b; t.s = s; t.lit = 1'b1; t.e = '{r, o};
        stim_q.push_back(t);
    endtask

    // Drives queued stimulus back-to-back; out_ready_i is low for cycles
    // stall_lo..stall_hi, or random when rnd_rdy is set.
    task automatic pump(input int stall_lo, input int stall_hi, input bit rnd_rdy);
        int c = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && c < 200) begin
            out_ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : !(c >= stall_lo && c <= stall_hi);
            if (stim_q.size() > 0) begin
                in_valid_i    = 1'b1;
                mult_i1       = stim_q[0].a;
                mult_i2       = stim_q[0].b;
                mult_signed_i = stim_q[0].s;
            end else begin
                in_valid_i = 1'b0;
            end
            @(negedge clk);
            if (in_valid_i && in_ready_o) begin
                exp_q.push_back(stim_q[0].lit ? stim_q[0].e
                                              : model(stim_q[0].a, stim_q[0].b, stim_q[0].s));
                void'(stim_q.pop_front());
            end
            @(posedge clk);
            #1;
            c++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        check("pump_drain", 32'(c < 200), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else if (out_valid_o && out_ready_i) begin
            n_out++;
            held_v = 1'b0;
            check("out_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("mult_o", 32'(mult_o), 32'(mon_e.r));
                check("mult_ovf_o", 32'(mult_ovf_o), 32'(mon_e.o));
            end
        end else if (out_valid_o) begin
            check("stall_in_ready", 32'(in_ready_o), 32'd0);
            if (held_v) check("stall_hold", 32'(mult_o), 32'(held_r));
            held_v = 1'b1;
            held_r = mult_o;
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_mult_o", 32'(mult_o), 32'd0);
        check("rst_ovf", 32'(mult_ovf_o), 32'd0);
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1 out_ready_i = 1'b1;

        // Latency: 1.5 x 2.0
        in_valid_i = 1'b1; mult_i1 = 16'h0180; mult_i2 = 16'h0200; mult_signed_i = 1'b1;
        @(negedge clk);
        check("lat_accept", 32'(in_ready_o), 32'd1);
        exp_q.push_back('{16'h0300, 1'b0});
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        @(negedge clk); check("lat_c1", 32'(out_valid_o), 32'd0);
        @(negedge clk); check("lat_c2", 32'(out_valid_o), 32'd0);
        @(negedge clk); check("lat_c3", 32'(out_valid_o), 32'd1);
        @(posedge clk);
        #1 check("lat_drained", 32'(exp_q.size()), 32'd0);

        // Rounding and saturation corners
        add_lit(16'h0001, 16'h0080, 1'b1, 16'h0001, 1'b0);
        add_lit(16'hFFFF, 16'h0080, 1'b1, 16'h0000, 1'b0);
        add_lit(16'h7F00, 16'h0200, 1'b1, 16'h7FFF, 1'b1);
        add_lit(16'h8000, 16'h0200, 1'b1, 16'h8000, 1'b1);
        add_lit(16'hFF00, 16'h0200, 1'b0, 16'hFFFF, 1'b1);
        pump(1000, 0, 1'b0);

        // Backpressure: six back-to-back, output stalled cycles 4-7
        n0 = n_out;
        add(16'h0100, 16'h0300, 1'b1);
        add(16'h0280, 16'h0040, 1'b0);
        add(16'hFE00, 16'h0180, 1'b1);
        add(16'h1234, 16'h0056, 1'b0);
        add(16'h8001, 16'h7FFF, 1'b1);
        add(16'h00FF, 16'h00FF, 1'b0);
        pump(4, 7, 1'b0);
        check("bp_count", 32'(n_out - n0), 32'd6);

        // Mixed mode back-to-back
        add_lit(16'hFF00, 16'h0100, 1'b1, 16'hFF00, 1'b0);
        add_lit(16'hFF00, 16'h0100, 1'b0, 16'hFF00, 1'b0);
        add_lit(16'hFF00, 16'h0100, 1'b1, 16'hFF00, 1'b0);
        add_lit(16'hFF00, 16'h0100, 1'b0, 16'hFF00, 1'b0);
        pump(1000, 0, 1'b0);

        // Random operands and modes under random backpressure
        n0 = n_out;
        for (int i = 0; i < 20; i++) begin
            add(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        pump(0, 0, 1'b1);
        check("rnd_count", 32'(n_out - n0), 32'd20);

        // Reset with two transactions in flight
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; mult_i1 = 16'h0100; mult_i2 = 16'h0100; mult_signed_i = 1'b1;
        @(posedge clk);
        #1 mult_i1 = 16'h0200;
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(out_valid_o), 32'd0);
        check("rst_async_mult_o", 32'(mult_o), 32'd0);
        check("rst_async_ovf", 32'(mult_ovf_o), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst2", 32'(in_ready_o), 32'd1);
        out_ready_i = 1'b1;
        n0 = n_out;
        repeat (8) @(negedge clk);
        check("no_out_after_rst", 32'(n_out - n0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_fx_pipe.md
MULT_FX_PIPE -- requirements
Module: mult_fx_pipe

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits.
REQ-002 Parameter FRAC, default 16: fractional bits of the fixed-point format; legal range 0 <= FRAC < WIDTH.
REQ-003 Parameter STAGES, default 3: pipeline latency in cycles; legal minimum is 1.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid_i  input  1  operands valid.
REQ-007 in_ready_o  output  1  block accepts operands this cycle.
REQ-008 mult_signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-009 mult_i1, mult_i2  input  WIDTH each  fixed-point operands.
REQ-010 out_valid_o  output  1  result valid.
REQ-011 out_ready_i  input  1  consumer accepts the result.
REQ-012 mult_o  output  WIDTH  rounded, saturated fixed-point product.
REQ-013 mult_ovf_o  output  1  saturation occurred for this result; qualified by out_valid_o.

Function
REQ-014 Transfer rules:
- An input transfer occurs when in_valid_i and in_ready_o are both high.
- An output transfer occurs when out_valid_o and out_ready_i are both high.
REQ-015 Global advance enable en = !out_valid_o || out_ready_i; in_ready_o SHALL equal en. This combinational path from out_ready_i is intentional.
REQ-016 When en is high, every stage's valid bit and data SHALL shift one stage; stage 0 loads in_valid_i and the operands.
REQ-017 When en is low, all stages, mult_o, mult_ovf_o and out_valid_o SHALL hold unchanged.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid_o when not stalled; throughput SHALL be one result per cycle.
REQ-019 Ordering and integrity: results SHALL leave in acceptance order, with no loss, duplication or reordering under any out_ready_i pattern.
REQ-020 Arithmetic, in order:
- full product P of 2*WIDTH bits, signed or unsigned per mult_signed_i;
- add rounding constant 2^(FRAC-1) when FRAC > 0, in a 2*WIDTH+1-bit intermediate (round half up);
- shift right by FRAC (arithmetic shift when signed).
REQ-021 Saturation:
- Signed results outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] SHALL clamp to the nearest bound with mult_ovf_o = 1.
- Unsigned results above 2^WIDTH-1 SHALL clamp to all-ones with mult_ovf_o = 1.
- Otherwise mult_ovf_o = 0.
REQ-022 The mult_signed_i mode SHALL travel with its operands, so mixed-mode back-to-back transactions are each computed in their own mode.
REQ-023 Pipeline split: multiplication SHALL occupy stages 0..STAGES-2; round and saturate SHALL be in the final stage. When STAGES = 1, all operations SHALL be in one registered stage.
REQ-024 Simultaneous input and output transfer in the same cycle SHALL be legal and lossless.
REQ-025 Bubbles (in_valid_i low while en is high) SHALL propagate as invalid stages and never produce out_valid_o.

Reset
REQ-026 While rst is high, the following SHALL be 0 immediately (asynchronously): all stage valid bits, out_valid_o, mult_o, mult_ovf_o.
REQ-027 In-flight transactions at reset assertion SHALL be discarded and never emitted.
REQ-028 in_ready_o SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-029 Package mult_pkg SHALL hold:
- the rounding-constant function;
- the signed and unsigned saturation-bound functions, parametrised by width.
REQ-030 The pipeline SHALL use exactly one combinational sub-module, mult_rnd_sat, which takes P, the mode bit and FRAC and returns the result and overflow flag; it is instantiated in the final stage.
REQ-031 Stage valid bits and data SHALL be generate-built arrays indexed 0..STAGES-1; no hard-coded stage count.

Verification (WIDTH=16, FRAC=8, STAGES=3)
REQ-032 Signed 0x0180 x 0x0200 (1.5 x 2.0) -> mult_o = 0x0300, mult_ovf_o = 0, out_valid_o exactly 3 cycles after acceptance.
REQ-033 Rounding, signed mode:
- 0x0001 x 0x0080 -> 0x0001;
- 0xFFFF x 0x0080 -> 0x0000;
- mult_ovf_o = 0 for both.
REQ-034 Saturation, mult_ovf_o = 1 for all three:
- signed 0x7F00 x 0x0200 -> 0x7FFF;
- signed 0x8000 x 0x0200 -> 0x8000;
- unsigned 0xFF00 x 0x0200 -> 0xFFFF.
REQ-035 Backpressure: 6 back-to-back transactions with out_ready_i low for cycles 4-7 -> mult_o held stable, in_ready_o low during the stall, all 6 results in order with no duplicates.
REQ-036 Mixed mode: alternating mult_signed_i on 0xFF00 x 0x0100 -> signed 0xFF00, unsigned 0xFF00, each mult_ovf_o = 0.
REQ-037 Reset mid-stream: rst asserted with 2 transactions in flight -> out_valid_o = 0 in the same cycle, no result emitted after release, and in_ready_o = 1 in the first cycle after rst deasserts.
